// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write arbiter.
// Optional macro FB_FILL_CLIP_EN enables fill clipping to the screen.
package fb_pkg;

  localparam int FB_WIDTH    = 1024;
  localparam int FB_HEIGHT   = 768;
  localparam int ADDR_WIDTH  = 20;
  localparam int COORD_WIDTH = 10;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x0;
    logic [COORD_WIDTH-1:0] y0;
    logic [COORD_WIDTH-1:0] x1;
    logic [COORD_WIDTH-1:0] y1;
    logic                   color;
  } fill_cmd_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// CPU single-pixel write channel (valid/ready handshake).
// Master is the CPU side, slave is the arbiter.
interface fb_write_arbiter_if;
  import fb_pkg::*;

  logic                  cpu_wr_valid;
  logic                  cpu_wr_ready;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic                  cpu_wr_data;

  modport master (
    output cpu_wr_valid,
    output cpu_wr_addr,
    output cpu_wr_data,
    input  cpu_wr_ready
  );

  modport slave (
    input  cpu_wr_valid,
    input  cpu_wr_addr,
    input  cpu_wr_data,
    output cpu_wr_ready
  );

endinterface

// File: rtl/fb_fill_seq.sv
// Rectangle-fill sequencer: corner normalisation, row-major counters.
// FB_FILL_CLIP_EN clamps the rectangle to the visible screen.
module fb_fill_seq
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  fill_cmd_t             cmd,
  input  logic                  grant,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  color,
  output logic                  last,
  output logic                  empty
);

  fb_state_e state, state_n;

  logic [COORD_WIDTH-1:0] xmin, xmax;
  logic [COORD_WIDTH-1:0] ymin, ymax;
  logic [COORD_WIDTH-1:0] cx, cy;

  logic [COORD_WIDTH-1:0] nx_min, nx_max;
  logic [COORD_WIDTH-1:0] ny_min, ny_max;
  logic                   go;
  logic                   oob;

  assign go = start && (state == IDLE);

  always_comb begin
    nx_min = (cmd.x0 < cmd.x1) ? cmd.x0 : cmd.x1;
    nx_max = (cmd.x0 < cmd.x1) ? cmd.x1 : cmd.x0;
    ny_min = (cmd.y0 < cmd.y1) ? cmd.y0 : cmd.y1;
    ny_max = (cmd.y0 < cmd.y1) ? cmd.y1 : cmd.y0;
    oob    = 1'b0;
`ifdef FB_FILL_CLIP_EN
    if (32'(nx_max) > FB_WIDTH - 1)
      nx_max = COORD_WIDTH'(FB_WIDTH - 1);
    if (32'(ny_max) > FB_HEIGHT - 1)
      ny_max = COORD_WIDTH'(FB_HEIGHT - 1);
    oob = (32'(nx_min) >= FB_WIDTH) ||
          (32'(ny_min) >= FB_HEIGHT);
`endif
  end

  assign empty = go && oob;
  assign req   = (state == FILL);
  assign last  = (cx == xmax) && (cy == ymax);
  assign addr  = ADDR_WIDTH'({cy, cx});

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (go && !oob) state_n = FILL;
      FILL: if (grant && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xmin  <= '0;
      xmax  <= '0;
      ymin  <= '0;
      ymax  <= '0;
      cx    <= '0;
      cy    <= '0;
      color <= 1'b0;
    end else begin
      state <= state_n;
      if (go) begin
        xmin  <= nx_min;
        xmax  <= nx_max;
        ymin  <= ny_min;
        ymax  <= ny_max;
        cx    <= nx_min;
        cy    <= ny_min;
        color <= cmd.color;
      end else if (req && grant) begin
        if (cx == xmax) begin
          cx <= xmin;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between CPU stores and the fill engine.
// Optional macro FB_FILL_CLIP_EN clips fills to the visible screen.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fb_write_arbiter_if.slave      cpu,
  input  logic                   fill_start,
  input  logic [COORD_WIDTH-1:0] fill_x0,
  input  logic [COORD_WIDTH-1:0] fill_y0,
  input  logic [COORD_WIDTH-1:0] fill_x1,
  input  logic [COORD_WIDTH-1:0] fill_y1,
  input  logic                   fill_color,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   fb_we,
  output logic [ADDR_WIDTH-1:0]  fb_addr,
  output logic                   fb_din
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  fill_cmd_t             cmd;
  logic                  seq_req;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  seq_color;
  logic                  seq_last;
  logic                  seq_empty;

  logic [CW-1:0] starve_cnt;
  logic          force_fill;
  logic          cpu_gnt;
  logic          fill_gnt;

  assign cmd = '{
    x0:    fill_x0,
    y0:    fill_y0,
    x1:    fill_x1,
    y1:    fill_y1,
    color: fill_color
  };

  fb_fill_seq u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (fill_start),
    .cmd   (cmd),
    .grant (fill_gnt),
    .req   (seq_req),
    .addr  (seq_addr),
    .color (seq_color),
    .last  (seq_last),
    .empty (seq_empty)
  );

  assign fill_busy  = seq_req;
  assign force_fill = seq_req &&
                      (starve_cnt == CW'(STARVE_LIMIT));
  assign cpu.cpu_wr_ready = !force_fill;
  assign cpu_gnt  = cpu.cpu_wr_valid && !force_fill;
  assign fill_gnt = seq_req && !cpu_gnt;

  // Saturating count of CPU wins while a fill waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!seq_req || fill_gnt) begin
      starve_cnt <= '0;
    end else if (cpu_gnt &&
                 starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_din    <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fb_we     <= cpu_gnt || fill_gnt;
      fill_done <= (fill_gnt && seq_last) || seq_empty;
      unique case (1'b1)
        cpu_gnt: begin
          fb_addr <= cpu.cpu_wr_addr;
          fb_din  <= cpu.cpu_wr_data;
        end
        fill_gnt: begin
          fb_addr <= seq_addr;
          fb_din  <= seq_color;
        end
        default: ;
      endcase
    end
  end

endmodule
